sdr_ch3_arbiter: RTL and testbench

Arbiter/sequencer for SDRAM channel 3. It shares the single ch3 port between three requesters:
- the ROM-loader write stream, used during download;
- the BG2 tile fetcher (read);
- the tilemap fetcher (read), which gives the commented-out map channel a home.
It sits between rom_loader/XSleenaCore and the sdram controller. It replaces the combinational ch3 muxing with registered, one-owner-at-a-time sequencing, a fixed priority plus round-robin policy, and a watchdog.

---
 rtl/xain_pkg.sv | 19 +
 rtl/sdr_req_tracker.sv | 30 +++
 rtl/sdr_ch3_arbiter.sv | 147 ++++++++++++++
 tb/tb_sdr_ch3_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xain_pkg.sv
// Shared types and defaults for the XSleena SDRAM channel-3 arbitration slice.
// Owner encoding doubles as the external owner port value.
package xain_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_ROM,
        OWN_BG2,
        OWN_MAP
    } ch3_owner_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } ch3_arb_state_t;

    localparam int CH3_TIMEOUT_DEF = 64;

endpackage

// File: rtl/sdr_req_tracker.sv
// Toggle/ack handshake tracker for one ch3 requester: exposes the pending bit
// and turns the arbiter's completion strobe into a registered one-cycle rdy.
module sdr_req_tracker (
    input  logic clk,
    input  logic RSTn,
    input  logic req,
    input  logic done,
    output logic pending,
    output logic rdy
);

    logic ack;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            // Ack follows req through reset so nothing is pending afterwards.
            ack <= req;
            rdy <= 1'b0;
        end else begin
            rdy <= done;
            if (done) begin
                ack <= req;
            end
        end
    end

    assign pending = req ^ ack;

endmodule

// File: rtl/sdr_ch3_arbiter.sv
// Registered one-owner-at-a-time sequencer for SDRAM ch3: ROM download writes,
// BG2 tile reads and tilemap reads, with round-robin between reads and a watchdog.
module sdr_ch3_arbiter
    import xain_pkg::*;
#(
    parameter int TIMEOUT = CH3_TIMEOUT_DEF,
    parameter int ADDR_W  = 25
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              dl_active,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_din,
    input  logic [1:0]        rom_be,
    input  logic              rom_req,
    output logic              rom_rdy,
    input  logic [ADDR_W-1:0] bg2_addr,
    input  logic              bg2_req,
    output logic [15:0]       bg2_dout,
    output logic              bg2_rdy,
    input  logic [ADDR_W-1:0] map_addr,
    input  logic              map_req,
    output logic [15:0]       map_dout,
    output logic              map_rdy,
    output logic [ADDR_W-2:0] sdr_addr,
    output logic [15:0]       sdr_din,
    output logic [1:0]        sdr_be,
    output logic              sdr_rnw,
    output logic              sdr_req,
    input  logic [15:0]       sdr_dout,
    input  logic              sdr_rdy,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    ch3_arb_state_t state;
    ch3_owner_t     owner_q;
    ch3_owner_t     rr_last;
    ch3_owner_t     win;
    logic [7:0]     wd_cnt;
    logic           rom_pend, bg2_pend, map_pend;
    logic           finish;
    logic           unused_addr_lsbs;

    // Byte-address LSBs have no meaning on the 16-bit word-addressed SDRAM side.
    assign unused_addr_lsbs = ^{rom_addr[0], bg2_addr[0], map_addr[0]};

    assign finish = (state == ARB_WAIT) && (sdr_rdy || (wd_cnt == WD_LAST));
    assign owner  = owner_q;

    sdr_req_tracker u_rom_trk (
        .clk(clk), .RSTn(RSTn), .req(rom_req),
        .done(finish && (owner_q == OWN_ROM)), .pending(rom_pend), .rdy(rom_rdy)
    );

    sdr_req_tracker u_bg2_trk (
        .clk(clk), .RSTn(RSTn), .req(bg2_req),
        .done(finish && (owner_q == OWN_BG2)), .pending(bg2_pend), .rdy(bg2_rdy)
    );

    sdr_req_tracker u_map_trk (
        .clk(clk), .RSTn(RSTn), .req(map_req),
        .done(finish && (owner_q == OWN_MAP)), .pending(map_pend), .rdy(map_rdy)
    );

    // NOTE: win gets a default before any branch so no latch is inferred.
    always_comb begin
        win = OWN_NONE;
        if (dl_active) begin
            if (rom_pend) win = OWN_ROM;
        end else if (bg2_pend && map_pend) begin
            win = (rr_last == OWN_MAP) ? OWN_BG2 : OWN_MAP;
        end else if (bg2_pend) begin
            win = OWN_BG2;
        end else if (map_pend) begin
            win = OWN_MAP;
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state       <= ARB_IDLE;
            owner_q     <= OWN_NONE;
            rr_last     <= OWN_MAP;
            wd_cnt      <= 8'd0;
            sdr_addr    <= '0;
            sdr_din     <= 16'h0000;
            sdr_be      <= 2'b11;
            sdr_rnw     <= 1'b1;
            sdr_req     <= 1'b0;
            bg2_dout    <= 16'h0000;
            map_dout    <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (win != OWN_NONE) begin
                        owner_q <= win;
                        sdr_req <= ~sdr_req;
                        sdr_din <= rom_din;
                        wd_cnt  <= 8'd0;
                        state   <= ARB_WAIT;
                        unique case (win)
                            OWN_ROM: begin
                                sdr_addr <= rom_addr[ADDR_W-1:1];
                                sdr_be   <= rom_be;
                                sdr_rnw  <= 1'b0;
                            end
                            OWN_BG2: begin
                                sdr_addr <= bg2_addr[ADDR_W-1:1];
                                sdr_be   <= 2'b11;
                                sdr_rnw  <= 1'b1;
                            end
                            default: begin
                                sdr_addr <= map_addr[ADDR_W-1:1];
                                sdr_be   <= 2'b11;
                                sdr_rnw  <= 1'b1;
                            end
                        endcase
                    end
                end
                ARB_WAIT: begin
                    if (sdr_rdy) begin
                        if (owner_q == OWN_BG2) bg2_dout <= sdr_dout;
                        if (owner_q == OWN_MAP) map_dout <= sdr_dout;
                        if (owner_q != OWN_ROM) rr_last <= owner_q;
                        owner_q <= OWN_NONE;
                        state   <= ARB_IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        // Abort: requester still gets its rdy, reads see all-ones.
                        timeout_err <= 1'b1;
                        if (owner_q == OWN_BG2) bg2_dout <= 16'hFFFF;
                        if (owner_q == OWN_MAP) map_dout <= 16'hFFFF;
                        owner_q <= OWN_NONE;
                        state   <= ARB_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// Self-checking bench for sdr_ch3_arbiter: directed vector table, hand sequences
// for reset/timeout corners, and a randomized BG2/MAP stream against a model.
module tb_sdr_ch3_arbiter;

    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              RSTn = 1'b0;
    logic              dl_active = 1'b0;
    logic [ADDR_W-1:0] rom_addr = 25'h00_1234;
    logic [15:0]       rom_din = 16'hA55A;
    logic [1:0]        rom_be = 2'b01;
    logic              rom_req = 1'b0;
    logic [ADDR_W-1:0] bg2_addr = 25'h00_2468;
    logic              bg2_req = 1'b0;
    logic [ADDR_W-1:0] map_addr = 25'h01_3579;
    logic              map_req = 1'b0;
    logic [15:0]       sdr_dout = 16'h0000;
    logic              sdr_rdy = 1'b0;

    logic              rom_rdy, bg2_rdy, map_rdy, sdr_rnw, sdr_req, timeout_err;
    logic [15:0]       bg2_dout, map_dout, sdr_din;
    logic [ADDR_W-2:0] sdr_addr;
    logic [1:0]        sdr_be, owner;

    logic              t8_rom_rdy, t8_bg2_rdy, t8_map_rdy, t8_sdr_rnw, t8_sdr_req, t8_timeout_err;
    logic [15:0]       t8_bg2_dout, t8_map_dout, t8_sdr_din;
    logic [ADDR_W-2:0] t8_sdr_addr;
    logic [1:0]        t8_sdr_be, t8_owner;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdr_ch3_arbiter #(.TIMEOUT(64), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .RSTn(RSTn), .dl_active(dl_active),
        .rom_addr(rom_addr), .rom_din(rom_din), .rom_be(rom_be), .rom_req(rom_req), .rom_rdy(rom_rdy),
        .bg2_addr(bg2_addr), .bg2_req(bg2_req), .bg2_dout(bg2_dout), .bg2_rdy(bg2_rdy),
        .map_addr(map_addr), .map_req(map_req), .map_dout(map_dout), .map_rdy(map_rdy),
        .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_be(sdr_be), .sdr_rnw(sdr_rnw), .sdr_req(sdr_req),
        .sdr_dout(sdr_dout), .sdr_rdy(sdr_rdy), .owner(owner), .timeout_err(timeout_err)
    );

    sdr_ch3_arbiter #(.TIMEOUT(8), .ADDR_W(ADDR_W)) dut_t8 (
        .clk(clk), .RSTn(RSTn), .dl_active(dl_active),
        .rom_addr(rom_addr), .rom_din(rom_din), .rom_be(rom_be), .rom_req(rom_req), .rom_rdy(t8_rom_rdy),
        .bg2_addr(bg2_addr), .bg2_req(bg2_req), .bg2_dout(t8_bg2_dout), .bg2_rdy(t8_bg2_rdy),
        .map_addr(map_addr), .map_req(map_req), .map_dout(t8_map_dout), .map_rdy(t8_map_rdy),
        .sdr_addr(t8_sdr_addr), .sdr_din(t8_sdr_din), .sdr_be(t8_sdr_be), .sdr_rnw(t8_sdr_rnw),
        .sdr_req(t8_sdr_req), .sdr_dout(sdr_dout), .sdr_rdy(sdr_rdy), .owner(t8_owner),
        .timeout_err(t8_timeout_err)
    );

    typedef struct {
        logic        rst;
        logic        dl;
        logic        t_rom;
        logic        t_bg2;
        logic        t_map;
        logic        rdy;
        logic [15:0] dout;
        logic [1:0]  own;
        logic        req;
        logic [2:0]  rdys;
        logic [23:0] addr;
        logic        rnw;
        logic [1:0]  be;
        logic [15:0] din;
        logic [15:0] bdout;
        logic [15:0] mdout;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RSTn    = 1'b0;
        sdr_rdy = 1'b0;
        tick();
        RSTn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  exp_rdys;
        logic [1:0]  m_owner, last, w;
        logic        m_busy, m_req, pend_b, pend_m, rdy_drv;
        logic [15:0] data_drv, m_bd, m_md;
        int          wcnt, dly, done_cnt, cycles;

        //  rst   dl    trom  tbg2  tmap  rdy   dout      own   req   rdys    addr        rnw   be     din       bdout     mdout
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,16'h0000,2'd1,1'b1,3'b000,24'h00091A,1'b0,2'b01,16'hA55A,16'h0000,16'h0000};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,2'd1,1'b1,3'b000,24'h00091A,1'b0,2'b01,16'hA55A,16'h0000,16'h0000};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,16'h0000,2'd0,1'b1,3'b100,24'h00091A,1'b0,2'b01,16'hA55A,16'h0000,16'h0000};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,2'd0,1'b1,3'b000,24'h00091A,1'b0,2'b01,16'hA55A,16'h0000,16'h0000};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,2'd0,1'b1,3'b000,24'h00091A,1'b0,2'b01,16'hA55A,16'h0000,16'h0000};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,2'd2,1'b0,3'b000,24'h001234,1'b1,2'b11,16'hA55A,16'h0000,16'h0000};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'h1111,2'd0,1'b0,3'b010,24'h001234,1'b1,2'b11,16'hA55A,16'h1111,16'h0000};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,2'd3,1'b1,3'b000,24'h009ABC,1'b1,2'b11,16'hA55A,16'h1111,16'h0000};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h2222,2'd0,1'b1,3'b001,24'h009ABC,1'b1,2'b11,16'hA55A,16'h1111,16'h2222};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000,2'd2,1'b0,3'b000,24'h001234,1'b1,2'b11,16'hA55A,16'h1111,16'h2222};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,2'd0,1'b0,3'b000,24'h000000,1'b1,2'b11,16'h0000,16'h0000,16'h0000};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000,2'd2,1'b1,3'b000,24'h001234,1'b1,2'b11,16'hA55A,16'h0000,16'h0000};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h1111,2'd0,1'b1,3'b010,24'h001234,1'b1,2'b11,16'hA55A,16'h1111,16'h0000};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,2'd3,1'b0,3'b000,24'h009ABC,1'b1,2'b11,16'hA55A,16'h1111,16'h0000};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h2222,2'd0,1'b0,3'b001,24'h009ABC,1'b1,2'b11,16'hA55A,16'h1111,16'h2222};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,2'd0,1'b0,3'b000,24'h009ABC,1'b1,2'b11,16'hA55A,16'h1111,16'h2222};

        // Reset state
        do_reset();
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_sdr_req", 32'(sdr_req), 32'd0);
        check("rst_sdr_rnw", 32'(sdr_rnw), 32'd1);
        check("rst_sdr_be", 32'(sdr_be), 32'd3);
        check("rst_rdys", 32'({rom_rdy, bg2_rdy, map_rdy}), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            RSTn      = ~tbl[i].rst;
            dl_active = tbl[i].dl;
            if (tbl[i].t_rom) rom_req = ~rom_req;
            if (tbl[i].t_bg2) bg2_req = ~bg2_req;
            if (tbl[i].t_map) map_req = ~map_req;
            sdr_rdy  = tbl[i].rdy;
            sdr_dout = tbl[i].dout;
            tick();
            check($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].own));
            check($sformatf("vec%0d_sdr_req", i), 32'(sdr_req), 32'(tbl[i].req));
            check($sformatf("vec%0d_rdys", i), 32'({rom_rdy, bg2_rdy, map_rdy}), 32'(tbl[i].rdys));
            check($sformatf("vec%0d_sdr_addr", i), 32'(sdr_addr), 32'(tbl[i].addr));
            check($sformatf("vec%0d_sdr_rnw", i), 32'(sdr_rnw), 32'(tbl[i].rnw));
            check($sformatf("vec%0d_sdr_be", i), 32'(sdr_be), 32'(tbl[i].be));
            check($sformatf("vec%0d_sdr_din", i), 32'(sdr_din), 32'(tbl[i].din));
            check($sformatf("vec%0d_bg2_dout", i), 32'(bg2_dout), 32'(tbl[i].bdout));
            check($sformatf("vec%0d_map_dout", i), 32'(map_dout), 32'(tbl[i].mdout));
        end
        RSTn    = 1'b1;
        sdr_rdy = 1'b0;

        // Reset in the middle of a MAP read: no rdy, late sdr_rdy ignored
        map_req = ~map_req;
        tick();
        check("mid_grant_owner", 32'(owner), 32'd3);
        tick();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_sdr_req", 32'(sdr_req), 32'd0);
        check("mid_rst_sdr_addr", 32'(sdr_addr), 32'd0);
        check("mid_rst_map_rdy", 32'(map_rdy), 32'd0);
        sdr_rdy  = 1'b1;
        sdr_dout = 16'hBEEF;
        tick();
        sdr_rdy = 1'b0;
        check("late_rdy_map_rdy", 32'(map_rdy), 32'd0);
        check("late_rdy_map_dout", 32'(map_dout), 32'd0);
        tick();
        check("late_rdy_map_rdy2", 32'(map_rdy), 32'd0);
        check("late_rdy_owner", 32'(owner), 32'd0);
        map_req = ~map_req;
        tick();
        check("fresh_map_owner", 32'(owner), 32'd3);
        check("fresh_map_sdr_req", 32'(sdr_req), 32'd1);
        sdr_rdy  = 1'b1;
        sdr_dout = 16'h3333;
        tick();
        sdr_rdy = 1'b0;
        check("fresh_map_rdy", 32'(map_rdy), 32'd1);
        check("fresh_map_dout", 32'(map_dout), 32'h3333);
        tick();
        check("fresh_map_rdy_drop", 32'(map_rdy), 32'd0);

        // Watchdog with TIMEOUT=8 on dut_t8
        do_reset();
        bg2_req = ~bg2_req;
        tick();
        check("to_grant_owner", 32'(t8_owner), 32'd2);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("to_wait%0d_err", i), 32'(t8_timeout_err), 32'd0);
            check($sformatf("to_wait%0d_rdy", i), 32'(t8_bg2_rdy), 32'd0);
            check($sformatf("to_wait%0d_owner", i), 32'(t8_owner), 32'd2);
        end
        tick();
        check("to_fire_err", 32'(t8_timeout_err), 32'd1);
        check("to_fire_rdy", 32'(t8_bg2_rdy), 32'd1);
        check("to_fire_dout", 32'(t8_bg2_dout), 32'hFFFF);
        check("to_fire_owner", 32'(t8_owner), 32'd0);
        tick();
        check("to_after_rdy", 32'(t8_bg2_rdy), 32'd0);
        sdr_rdy  = 1'b1;
        sdr_dout = 16'h1234;
        tick();
        sdr_rdy = 1'b0;
        check("to_late_rdy", 32'(t8_bg2_rdy), 32'd0);
        check("to_late_dout", 32'(t8_bg2_dout), 32'hFFFF);
        tick();
        check("to_sticky_err", 32'(t8_timeout_err), 32'd1);
        check("to_late_owner", 32'(t8_owner), 32'd0);

        // Randomized back-to-back BG2/MAP stream against the reference model
        do_reset();
        dl_active = 1'b0;
        m_busy = 1'b0; m_owner = 2'd0; m_req = 1'b0; last = 2'd3;
        m_bd = 16'h0000; m_md = 16'h0000; rdy_drv = 1'b0; data_drv = 16'h0000;
        wcnt = 0; dly = 0; done_cnt = 0; cycles = 0;
        bg2_req = ~bg2_req; pend_b = 1'b1;
        map_req = ~map_req; pend_m = 1'b1;
        while (done_cnt < 200 && cycles < 6000) begin
            tick();
            cycles++;
            exp_rdys = 3'b000;
            if (!m_busy) begin
                if (pend_b || pend_m) begin
                    if (pend_b && pend_m) w = (last == 2'd3) ? 2'd2 : 2'd3;
                    else w = pend_b ? 2'd2 : 2'd3;
                    m_busy = 1'b1; m_owner = w; m_req = ~m_req;
                    wcnt = 0; dly = $urandom_range(2, 10);
                end
            end else if (rdy_drv) begin
                if (m_owner == 2'd2) begin
                    exp_rdys[1] = 1'b1; m_bd = data_drv; pend_b = 1'b0;
                end else begin
                    exp_rdys[0] = 1'b1; m_md = data_drv; pend_m = 1'b0;
                end
                last = m_owner; m_busy = 1'b0; m_owner = 2'd0;
                done_cnt++;
            end
            check($sformatf("rnd%0d_owner", cycles), 32'(owner), 32'(m_owner));
            check($sformatf("rnd%0d_sdr_req", cycles), 32'(sdr_req), 32'(m_req));
            check($sformatf("rnd%0d_rdys", cycles), 32'({rom_rdy, bg2_rdy, map_rdy}), 32'(exp_rdys));
            check($sformatf("rnd%0d_bg2_dout", cycles), 32'(bg2_dout), 32'(m_bd));
            check($sformatf("rnd%0d_map_dout", cycles), 32'(map_dout), 32'(m_md));
            rdy_drv = 1'b0;
            if (m_busy) begin
                wcnt++;
                if (wcnt == dly) begin
                    rdy_drv  = 1'b1;
                    data_drv = 16'($urandom);
                end
            end
            sdr_rdy  = rdy_drv;
            sdr_dout = data_drv;
            if (exp_rdys[1]) begin bg2_req = ~bg2_req; pend_b = 1'b1; end
            if (exp_rdys[0]) begin map_req = ~map_req; pend_m = 1'b1; end
        end
        sdr_rdy = 1'b0;
        check("rnd_completed", 32'(done_cnt), 32'd200);
        check("rnd_no_timeout", 32'(timeout_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
